// File: rtl/mem_access_if.sv
// EX/MEM request, MEM/WB writeback, stall and byte-wide RAM port of the memory stage.
// The slave modport is the memory stage itself; the master modport is its surroundings.
interface mem_access_if #(
    parameter int ADDR_W = 32
) ();
    logic              rdy;
    logic [7:0]        aluop_i;
    logic [31:0]       mem_addr_i;
    logic [31:0]       wdata_i;
    logic [4:0]        wd_i;
    logic              wreg_i;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic [31:0]       wdata_o;
    logic              stall_req_o;
    logic [ADDR_W-1:0] ram_a_o;
    logic [7:0]        ram_dout_o;
    logic              ram_wr_o;
    logic [7:0]        ram_din_i;

    modport slave (
        input  rdy, aluop_i, mem_addr_i, wdata_i, wd_i, wreg_i, ram_din_i,
        output wd_o, wreg_o, wdata_o, stall_req_o, ram_a_o, ram_dout_o, ram_wr_o
    );

    modport master (
        output rdy, aluop_i, mem_addr_i, wdata_i, wd_i, wreg_i, ram_din_i,
        input  wd_o, wreg_o, wdata_o, stall_req_o, ram_a_o, ram_dout_o, ram_wr_o
    );
endinterface

// File: rtl/mem_access.sv
// RV32I memory-access stage: performs loads/stores one byte per cycle on an 8-bit RAM
// port, stalling the pipeline while busy; non-memory ops pass straight through.
module mem_access #(
    parameter int ADDR_W = 32
) (
    input logic         clk,
    input logic         rst,
    mem_access_if.slave bus
);
    localparam logic [7:0] EX_LB  = 8'h20;
    localparam logic [7:0] EX_LH  = 8'h21;
    localparam logic [7:0] EX_LW  = 8'h22;
    localparam logic [7:0] EX_LBU = 8'h24;
    localparam logic [7:0] EX_LHU = 8'h25;
    localparam logic [7:0] EX_SB  = 8'h28;
    localparam logic [7:0] EX_SH  = 8'h29;
    localparam logic [7:0] EX_SW  = 8'h2A;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t            state, state_nx;
    logic [1:0]        k, k_nx;
    logic              rd_pend;
    logic [1:0]        rd_idx;
    logic [7:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       sdata;
    logic [4:0]        wd;
    logic              wreg;
    logic [31:0]       word;
    logic              latch, issue;
    logic [4:0]        wd_out;
    logic              wreg_out;
    logic [31:0]       wdata_out;
    logic              stall;
    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout;
    logic              ram_wr;

    function automatic logic is_load(input logic [7:0] o);
        case (o)
            EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [7:0] o);
        case (o)
            EX_SB, EX_SH, EX_SW: return 1'b1;
            default:             return is_load(o);
        endcase
    endfunction

    // Index of the last byte of the access (size minus one).
    function automatic logic [1:0] last_byte(input logic [7:0] o);
        case (o)
            EX_LB, EX_LBU, EX_SB: return 2'd0;
            EX_LH, EX_LHU, EX_SH: return 2'd1;
            default:              return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [7:0] o, input logic [31:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        b = w[7:0];
        h = w[15:0];
        case (o)
            EX_LB:   s = b;
            EX_LH:   s = h;
            EX_LBU:  s = {24'h0, w[7:0]};
            EX_LHU:  s = {16'h0, w[15:0]};
            default: s = w;
        endcase
        return s;
    endfunction

    always_comb begin
        state_nx  = state;
        k_nx      = k;
        latch     = 1'b0;
        issue     = 1'b0;
        stall     = 1'b0;
        wd_out    = '0;
        wreg_out  = 1'b0;
        wdata_out = '0;
        ram_a     = '0;
        ram_dout  = '0;
        ram_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem(bus.aluop_i)) begin
                    stall = 1'b1;
                    if (bus.rdy) begin
                        latch    = 1'b1;
                        k_nx     = 2'd0;
                        state_nx = ACCESS;
                    end
                end else begin
                    wd_out    = bus.wd_i;
                    wreg_out  = bus.wreg_i;
                    wdata_out = bus.wdata_i;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                ram_a = addr + ADDR_W'(k);
                if (!is_load(op)) ram_dout = sdata[{k, 3'b000} +: 8];
                if (bus.rdy) begin
                    ram_wr = !is_load(op);
                    issue  = is_load(op);
                    k_nx   = k + 2'd1;
                    if (k == last_byte(op)) state_nx = is_load(op) ? WAIT : DONE;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (bus.rdy) state_nx = DONE;
            end
            DONE: begin
                wd_out    = wd;
                wreg_out  = is_load(op) && wreg && (wd != 5'd0);
                wdata_out = is_load(op) ? extend(op, word) : 32'h0;
                if (bus.rdy) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            k       <= 2'd0;
            rd_pend <= 1'b0;
            rd_idx  <= 2'd0;
            op      <= '0;
            addr    <= '0;
            sdata   <= '0;
            wd      <= '0;
            wreg    <= 1'b0;
            word    <= '0;
        end else begin
            state   <= state_nx;
            k       <= k_nx;
            rd_pend <= issue;
            if (issue) rd_idx <= k;
            // RAM data lags its address by one cycle; capture regardless of rdy.
            if (rd_pend) word[{rd_idx, 3'b000} +: 8] <= bus.ram_din_i;
            if (latch) begin
                op    <= bus.aluop_i;
                addr  <= bus.mem_addr_i[ADDR_W-1:0];
                sdata <= bus.wdata_i;
                wd    <= bus.wd_i;
                wreg  <= bus.wreg_i;
            end
        end
    end

    assign bus.wd_o        = wd_out;
    assign bus.wreg_o      = wreg_out;
    assign bus.wdata_o     = wdata_out;
    assign bus.stall_req_o = stall;
    assign bus.ram_a_o     = ram_a;
    assign bus.ram_dout_o  = ram_dout;
    assign bus.ram_wr_o    = ram_wr;
endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: directed scenarios plus randomized load/store/pass-through
// traffic checked against a cycle-timeline reference model and a shadow memory.
`timescale 1ns/1ps
module tb_mem_access;
    localparam logic [7:0] EX_NOP = 8'h00;
    localparam logic [7:0] EX_ADD = 8'h01;
    localparam logic [7:0] EX_LB  = 8'h20;
    localparam logic [7:0] EX_LH  = 8'h21;
    localparam logic [7:0] EX_LW  = 8'h22;
    localparam logic [7:0] EX_LBU = 8'h24;
    localparam logic [7:0] EX_LHU = 8'h25;
    localparam logic [7:0] EX_SB  = 8'h28;
    localparam logic [7:0] EX_SH  = 8'h29;
    localparam logic [7:0] EX_SW  = 8'h2A;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   [7:0] ram    [bit [31:0]];
    bit   [7:0] shadow [bit [31:0]];
    logic [7:0] ram_q = 8'h0;
    logic [7:0] ops [10] = '{EX_NOP, EX_ADD, EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU, EX_SB, EX_SH, EX_SW};

    mem_access_if #(.ADDR_W(32)) bus ();
    mem_access #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic bit [7:0] init_byte(input bit [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic bit [7:0] ram_rd(input bit [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic bit [7:0] sh_rd(input bit [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_byte(a);
    endfunction

    // Synchronous RAM: one-cycle read latency, write on strobe.
    always @(posedge clk) begin
        ram_q <= ram_rd(bus.ram_a_o);
        if (bus.ram_wr_o) ram[bus.ram_a_o] = bus.ram_dout_o;
    end
    assign bus.ram_din_i = ram_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input bit [31:0] a, input bit [7:0] b);
        ram[a]    = b;
        shadow[a] = b;
    endtask

    task automatic drive_req(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                             input logic [4:0] wdv, input logic wrg);
        bus.aluop_i    = op;
        bus.mem_addr_i = a;
        bus.wdata_i    = d;
        bus.wd_i       = wdv;
        bus.wreg_i     = wrg;
    endtask

    // Memory op starting in the current cycle (cycle 0). lowmask bit i drops rdy in cycle i+1.
    task automatic mem_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] wdv, input logic wrg, input logic [3:0] lowmask);
        int n, e, c, served, dcyc, idx;
        bit ld;
        int issue_at [4];
        logic [31:0] w, exp_data;
        ld = op inside {EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU};
        n  = (op inside {EX_LB, EX_LBU, EX_SB}) ? 1 : (op inside {EX_LH, EX_LHU, EX_SH}) ? 2 : 4;
        e  = n + (ld ? 1 : 0);
        for (int j = 0; j < 4; j++) issue_at[j] = -1;
        c = 1;
        served = 0;
        while (served < e) begin
            if (!(c <= 4 && lowmask[c-1])) begin
                if (served < n) issue_at[served] = c;
                served++;
            end
            c++;
        end
        dcyc = c;
        w = 32'h0;
        for (int j = 0; j < n; j++) w = w | (32'(sh_rd(a + 32'(j))) << (8 * j));
        case (op)
            EX_LB:   exp_data = {{24{w[7]}}, w[7:0]};
            EX_LBU:  exp_data = {24'h0, w[7:0]};
            EX_LH:   exp_data = {{16{w[15]}}, w[15:0]};
            EX_LHU:  exp_data = {16'h0, w[15:0]};
            default: exp_data = w;
        endcase

        drive_req(op, a, d, wdv, wrg);
        bus.rdy = 1'b1;
        for (int cy = 0; cy <= dcyc; cy++) begin
            if (cy > 0) bus.rdy = (cy < dcyc && cy <= 4 && lowmask[cy-1]) ? 1'b0 : 1'b1;
            @(negedge clk);
            check("stall", 32'(bus.stall_req_o), 32'(cy < dcyc));
            idx = -1;
            for (int j = 0; j < n; j++) if (issue_at[j] == cy) idx = j;
            check("ram_wr", 32'(bus.ram_wr_o), 32'(!ld && idx >= 0));
            if (idx >= 0) begin
                check("ram_a", bus.ram_a_o, a + 32'(idx));
                if (!ld) check("ram_dout", 32'(bus.ram_dout_o), 32'(d[8*idx +: 8]));
            end
            if (cy == dcyc) begin
                check("done_wd", 32'(bus.wd_o), 32'(wdv));
                check("done_wreg", 32'(bus.wreg_o), 32'(ld && wrg && wdv != 5'd0));
                if (ld) check("done_wdata", bus.wdata_o, exp_data);
            end
            next_cycle();
        end
        if (!ld) begin
            for (int j = 0; j < n; j++) shadow[a + 32'(j)] = d[8*j +: 8];
            for (int j = 0; j < n; j++) check("store_mem", 32'(ram_rd(a + 32'(j))), 32'(sh_rd(a + 32'(j))));
        end
    endtask

    task automatic pass_op(input logic [7:0] op, input logic [31:0] d, input logic [4:0] wdv,
                           input logic wrg);
        drive_req(op, $urandom, d, wdv, wrg);
        bus.rdy = 1'b1;
        @(negedge clk);
        check("pt_wd", 32'(bus.wd_o), 32'(wdv));
        check("pt_wreg", 32'(bus.wreg_o), 32'(wrg));
        check("pt_wdata", bus.wdata_o, d);
        check("pt_stall", 32'(bus.stall_req_o), 32'h0);
        check("pt_wr", 32'(bus.ram_wr_o), 32'h0);
        next_cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wd"}, 32'(bus.wd_o), 32'h0);
        check({tag, "_wreg"}, 32'(bus.wreg_o), 32'h0);
        check({tag, "_wdata"}, bus.wdata_o, 32'h0);
        check({tag, "_stall"}, 32'(bus.stall_req_o), 32'h0);
        check({tag, "_ram_a"}, bus.ram_a_o, 32'h0);
        check({tag, "_dout"}, 32'(bus.ram_dout_o), 32'h0);
        check({tag, "_wr"}, 32'(bus.ram_wr_o), 32'h0);
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] a;

        rst = 1'b0;
        bus.rdy = 1'b1;
        drive_req(EX_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        next_cycle();
        rst = 1'b1;
        next_cycle();

        preload(32'h100, 8'h11);
        preload(32'h101, 8'h22);
        preload(32'h102, 8'h33);
        preload(32'h103, 8'h44);
        mem_op(EX_LW, 32'h100, 32'h0, 5'd5, 1'b1, 4'b0000);
        pass_op(EX_ADD, 32'h7, 5'd3, 1'b1);
        mem_op(EX_LW, 32'h100, 32'h0, 5'd6, 1'b1, 4'b0000);
        pass_op(EX_ADD, 32'h7, 5'd3, 1'b1);

        preload(32'h180, 8'h80);
        preload(32'h190, 8'h34);
        preload(32'h191, 8'h92);
        mem_op(EX_LB, 32'h180, 32'h0, 5'd7, 1'b1, 4'b0000);
        mem_op(EX_LBU, 32'h180, 32'h0, 5'd8, 1'b1, 4'b0000);
        mem_op(EX_LH, 32'h190, 32'h0, 5'd9, 1'b1, 4'b0000);
        mem_op(EX_SH, 32'h2, 32'hABCD1234, 5'd9, 1'b1, 4'b0000);
        mem_op(EX_LW, 32'h100, 32'h0, 5'd4, 1'b1, 4'b1100);
        preload(32'hFFFF_FFFF, 8'h01);
        preload(32'h0, 8'h80);
        mem_op(EX_LH, 32'hFFFF_FFFF, 32'h0, 5'd12, 1'b1, 4'b0000);
        mem_op(EX_LW, 32'h100, 32'h0, 5'd0, 1'b1, 4'b0000);

        // Reset lands in the cycle that would write byte 2 of a word store.
        drive_req(EX_SW, 32'h300, 32'hDEADBEEF, 5'd10, 1'b1);
        @(negedge clk);
        check("rs_stall0", 32'(bus.stall_req_o), 32'h1);
        next_cycle();
        for (int cy = 1; cy <= 2; cy++) begin
            @(negedge clk);
            check("rs_wr", 32'(bus.ram_wr_o), 32'h1);
            check("rs_a", bus.ram_a_o, 32'h300 + 32'(cy - 1));
            next_cycle();
        end
        rst = 1'b0;
        drive_req(EX_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        check_all_zero("rs");
        next_cycle();
        rst = 1'b1;
        shadow[32'h300] = 8'hEF;
        shadow[32'h301] = 8'hBE;
        for (int j = 0; j < 4; j++) check("rs_mem", 32'(ram_rd(32'h300 + 32'(j))), 32'(sh_rd(32'h300 + 32'(j))));

        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(0, 9)];
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                               : 32'h200 + 32'($urandom_range(0, 255));
            if (op == EX_NOP || op == EX_ADD)
                pass_op(op, $urandom, 5'($urandom), 1'($urandom));
            else
                mem_op(op, a, $urandom, 5'($urandom), 1'($urandom),
                       ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000);
        end

        drive_req(EX_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the pipelined RV32I core. It takes the load/store request that the execute stage places in the EX/MEM pipeline register (`aluop`, effective address, store data, destination register) and performs the access byte-serially on the 8-bit unified RAM port. It sign- or zero-extends load data and hands the writeback triple to MEM/WB. While an access is in flight it stalls the pipeline. Non-memory instructions pass straight through with no added latency.

## Interface
- `ADDR_W`, default 32: RAM address width; the upper address bits are truncated.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rdy` in 1: global run enable. When low, the block freezes (see Operation).
- `aluop_i` in `AluOpBus`: operation code. `EX_LB/LH/LW/LBU/LHU/SB/SH/SW` mean a memory op. Any other code, including `EX_NOP`, is a pass-through.
- `mem_addr_i` in 32: effective byte address.
- `wdata_i` in `RegBus`: ALU result for pass-through ops, or store data for stores.
- `wd_i` in `RegAddrBus`, `wreg_i` in 1: destination register and write enable.
- `wd_o` out `RegAddrBus`, `wreg_o` out 1, `wdata_o` out `RegBus`: writeback triple to MEM/WB.
- `stall_req_o` out 1: pipeline stall request to the controller.
- `ram_a_o` out `ADDR_W`, `ram_dout_o` out 8, `ram_wr_o` out 1: RAM address, write data and write strobe.
- `ram_din_i` in 8: RAM read data. Read latency is exactly 1 cycle.

## Operation
- Access size N: 1 for B/BU/SB, 2 for H/HU/SH, 4 for W/SW.
- Byte k is accessed at `mem_addr_i + k`, computed modulo 2^ADDR_W. Byte order is little-endian.
- No alignment is required; misaligned accesses are performed byte by byte like any other.
- FSM states are IDLE, ACCESS, WAIT and DONE. A byte counter `k` (0..3) and a flag `rd_pend` support the FSM.
- IDLE, non-memory op: `wd_o/wreg_o/wdata_o` equal their inputs combinationally and `stall_req_o` = 0.
- IDLE, memory op:
  - `stall_req_o` = 1 combinationally.
  - `aluop`, address, store data, `wd` and `wreg` are latched, `k` is set to 0, and the state becomes ACCESS.
  - Outputs: `wreg_o` = 0, `wdata_o` = 0, `wd_o` = 0.
- ACCESS: `ram_a_o` = latched address + k.
  - Store: `ram_wr_o` = 1 and `ram_dout_o` = store byte k.
  - Load: `ram_wr_o` = 0. `rd_pend` is set to 1 for the next cycle.
  - k increments each cycle.
  - After byte N-1: a store goes to DONE, a load goes to WAIT.
- Read capture: on every cycle with `rd_pend` = 1, `ram_din_i` is written into assembly byte (issue index). Capture is not gated by `rdy`.
- WAIT: captures the last byte, then goes to DONE.
- DONE:
  - `stall_req_o` = 0 and `ram_wr_o` = 0.
  - Outputs are registered: `wd_o` = latched wd. `wreg_o` = latched wreg for loads and 0 for stores.
  - Load result extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW takes all 32 bits.
  - The `aluop_i` presented during DONE is the already-served instruction and is ignored. DONE always goes to IDLE next cycle.
- A request with `wreg_i` = 1 and `wd_i` = 0 still performs the memory access. `wreg_o` is forced to 0.
- When `rdy` = 0:
  - State, k and latched fields hold and `ram_wr_o` = 0.
  - No new read is issued; `rd_pend` clears after its pending capture.
  - `stall_req_o` keeps its value.
- Reset (asynchronous, any state): goes to IDLE; k = 0, `rd_pend` = 0, and all latched/registered fields are 0.
  - Any partially written store is abandoned; bytes already written stay written.

## Timing
- Reset values: `wd_o` = 0, `wreg_o` = 0, `wdata_o` = 0, `stall_req_o` = 0, `ram_a_o` = 0, `ram_dout_o` = 0, `ram_wr_o` = 0.
- Cycle 0 is the IDLE cycle in which the request is seen. Latencies with `rdy` held high:
  - Store: writes in cycles 1..N, DONE in cycle N+1. `stall_req_o` is high in cycles 0..N.
  - Load: addresses issued in cycles 1..N, data captured in cycles 2..N+1, DONE in cycle N+2. `stall_req_o` is high in cycles 0..N+1.
- Back-to-back memory ops: after DONE (cycle D), the next request is seen in IDLE at D+1. There is no bubble other than DONE itself.
- Each `rdy`-low cycle adds exactly one cycle of latency.
- `ram_wr_o` is never high outside ACCESS.

## Test plan
- LW from 0x100, RAM bytes 11,22,33,44, wd = 5 → `ram_a_o` 0x100..0x103 in cycles 1-4; DONE cycle 6 shows `wd_o` = 5, `wreg_o` = 1, `wdata_o` = 0x44332211; stall high cycles 0-5.
- LB vs LBU from a byte holding 0x80 → `wdata_o` = 0xFFFFFF80 for LB and 0x00000080 for LBU; LH of bytes 0x34,0x92 → 0xFFFF9234.
- SH of 0xABCD1234 to 0x2 → cycle 1 writes 0x34@0x2, cycle 2 writes 0x12@0x3; DONE cycle 3 with `wreg_o` = 0; stall low in cycle 3.
- LW with `rdy` low for 2 cycles after the second address → no duplicate or skipped address; correct word in DONE 2 cycles late; `ram_wr_o` stays 0.
- Reset asserted during byte 2 of an SW → immediately IDLE with all outputs 0; only bytes 0-1 written. LH at 0xFFFFFFFF (`ADDR_W` = 32) → bytes read from 0xFFFFFFFF then 0x0.
- Pass-through ADD result 0x7, wd = 3, interleaved between two loads → same-cycle output with no stall; the load following DONE is served starting the next cycle.
